// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions: stall-level encodings and bus widths used by the
// pipeline control block and the stages it steers.
package pipe_ctrl_pkg;

  typedef logic [2:0]  Hold_Flag_Bus;
  typedef logic [31:0] RegBus;
  typedef logic [31:0] InstAddrBus;

  localparam InstAddrBus   ZeroWord  = 32'h0000_0000;

  // id_ex inserts a bubble whenever the level is >= Hold_Id
  localparam Hold_Flag_Bus Hold_None = 3'd0;
  localparam Hold_Flag_Bus Hold_Pc   = 3'd1;
  localparam Hold_Flag_Bus Hold_If   = 3'd2;
  localparam Hold_Flag_Bus Hold_Id   = 3'd3;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates redirects and stall sources into one hold level
// and a PC redirect, and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_i,
  input  InstAddrBus             jump_addr_i,
  input  logic                   int_assert_i,
  input  InstAddrBus             int_addr_i,
  input  logic                   hold_ex_i,
  input  logic                   hold_bus_i,
  input  logic                   load_use_i,
  output Hold_Flag_Bus           hold_flag_o,
  output logic                   jump_flag_o,
  output InstAddrBus             jump_addr_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] FLUSH  = 2'd1;
  localparam logic [1:0] EXWAIT = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic                   lu_flag;
  logic                   lu_flag_nxt;
  logic                   lu_fire;
  logic                   low_fire;
  Hold_Flag_Bus           low_lvl;
  logic [STALL_CNT_W-1:0] stall_cnt;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v == {STALL_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Sources below the EX stall: bus wait, then a single load-use bubble
  always_comb begin
    low_lvl  = Hold_None;
    low_fire = 1'b0;
    if (hold_bus_i) begin
      low_lvl = Hold_Pc;
    end else if (load_use_i && !lu_flag) begin
      low_lvl  = Hold_If;
      low_fire = 1'b1;
    end
  end

  always_comb begin
    hold_flag_o = Hold_None;
    jump_flag_o = 1'b0;
    jump_addr_o = ZeroWord;
    state_nxt   = state;
    lu_fire     = 1'b0;
    if (rst) begin
      state_nxt = RUN;
    end else if (int_assert_i) begin
      hold_flag_o = Hold_Id;
      jump_flag_o = 1'b1;
      jump_addr_o = int_addr_i;
      state_nxt   = FLUSH;
    end else if (jump_flag_i) begin
      hold_flag_o = Hold_Id;
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
      state_nxt   = FLUSH;
    end else begin
      case (state)
        FLUSH: begin
          hold_flag_o = Hold_Id;
          state_nxt   = RUN;
        end
        EXWAIT: begin
          if (hold_ex_i) begin
            hold_flag_o = Hold_Id;
          end else begin
            hold_flag_o = low_lvl;
            lu_fire     = low_fire;
            state_nxt   = RUN;
          end
        end
        default: begin
          state_nxt = RUN;
          if (hold_ex_i) begin
            hold_flag_o = Hold_Id;
            state_nxt   = EXWAIT;
          end else begin
            hold_flag_o = low_lvl;
            lu_fire     = low_fire;
          end
        end
      endcase
    end
  end

  // The flag stays armed for as long as the same hazard keeps load_use_i high
  assign lu_flag_nxt = load_use_i & (lu_flag | lu_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      lu_flag   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      lu_flag <= lu_flag_nxt;
      if (hold_flag_o != Hold_None) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end

  assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl against a cycle-level reference
// model of redirect, flush, stall and load-use behaviour.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        int_assert_i = 1'b0;
  logic [31:0] int_addr_i = '0;
  logic        hold_ex_i = 1'b0;
  logic        hold_bus_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [15:0] stall_cnt_o;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .int_assert_i (int_assert_i),
    .int_addr_i   (int_addr_i),
    .hold_ex_i    (hold_ex_i),
    .hold_bus_i   (hold_bus_i),
    .load_use_i   (load_use_i),
    .hold_flag_o  (hold_flag_o),
    .jump_flag_o  (jump_flag_o),
    .jump_addr_o  (jump_addr_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: pending flush cycle, load-use already served, stall count
  bit m_flush_pending = 1'b0;
  bit m_lu_served     = 1'b0;
  int m_stalls        = 0;

  logic [2:0]  obs_hold;
  logic        obs_jf;
  logic [31:0] obs_addr;
  logic [15:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs against the model, then advance the model
  task automatic step(input bit r, input bit ia, input logic [31:0] iaddr,
                      input bit jf, input logic [31:0] jaddr,
                      input bit hx, input bit hb, input bit lu);
    int          e_hold;
    bit          e_jf;
    logic [31:0] e_addr;
    bit          lu_bubble;
    @(negedge clk);
    rst = r; int_assert_i = ia; int_addr_i = iaddr; jump_flag_i = jf;
    jump_addr_i = jaddr; hold_ex_i = hx; hold_bus_i = hb; load_use_i = lu;
    #1;
    e_hold = 0; e_jf = 1'b0; e_addr = 32'h0; lu_bubble = 1'b0;
    if (!r) begin
      if (ia || jf) begin
        e_hold = 3; e_jf = 1'b1; e_addr = ia ? iaddr : jaddr;
      end else if (m_flush_pending || hx) begin
        e_hold = 3;
      end else if (hb) begin
        e_hold = 1;
      end else if (lu && !m_lu_served) begin
        e_hold = 2; lu_bubble = 1'b1;
      end
    end
    obs_hold = hold_flag_o; obs_jf = jump_flag_o; obs_addr = jump_addr_o; obs_cnt = stall_cnt_o;
    chk("hold_flag", {29'd0, obs_hold}, e_hold);
    chk("jump_flag", {31'd0, obs_jf}, {31'd0, e_jf});
    chk("jump_addr", obs_addr, e_addr);
    chk("stall_cnt", {16'd0, obs_cnt}, m_stalls);
    if (r) begin
      m_flush_pending = 1'b0; m_lu_served = 1'b0; m_stalls = 0;
    end else begin
      m_flush_pending = ia || jf;
      m_lu_served     = lu && (m_lu_served || lu_bubble);
      if (e_hold != 0 && m_stalls < 65535) m_stalls++;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // Single jump: redirect cycle plus one flush cycle
    do_reset();
    step(0, 0, 0, 1, 32'h80, 0, 0, 0);
    chk("jump_strobe", {31'd0, obs_jf}, 32'd1);
    chk("jump_target", obs_addr, 32'h80);
    idle();
    chk("flush_hold", {29'd0, obs_hold}, 32'd3);
    idle();
    chk("after_flush", {29'd0, obs_hold}, 32'd0);

    // Interrupt beats jump
    do_reset();
    step(0, 1, 32'h100, 1, 32'h80, 0, 0, 0);
    chk("int_prio", obs_addr, 32'h100);
    idle(); idle();

    // EX stall for five cycles
    do_reset();
    repeat (5) step(0, 0, 0, 0, 0, 1, 0, 0);
    idle();
    chk("exwait_exit", {29'd0, obs_hold}, 32'd0);
    chk("exwait_cnt", {16'd0, obs_cnt}, 32'd5);

    // Load-use held three cycles yields one bubble
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("lu_first", {29'd0, obs_hold}, 32'd2);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("lu_second", {29'd0, obs_hold}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle();

    // Back-to-back jumps restart the flush
    do_reset();
    step(0, 0, 0, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200, 0, 0, 0);
    chk("rejump_addr", obs_addr, 32'h200);
    idle();
    chk("rejump_flush", {29'd0, obs_hold}, 32'd3);
    idle();

    // Reset during EXWAIT leaves no residue
    do_reset();
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_override", {29'd0, obs_hold}, 32'd0);
    idle();
    chk("rst_exwait_hold", {29'd0, obs_hold}, 32'd0);
    chk("rst_exwait_cnt", {16'd0, obs_cnt}, 32'd0);

    // Reset overrides an active redirect
    step(1, 1, 32'h44, 1, 32'h88, 1, 1, 1);
    chk("rst_jump_flag", {31'd0, obs_jf}, 32'd0);

    // Random traffic with sparse sources
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 5), $urandom,
           ($urandom_range(0, 99) < 10), $urandom,
           ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 20),
           ($urandom_range(0, 99) < 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
